// File: rtl/mc_pkg.sv
// Shared definitions for the RV32I multicycle control unit: state encoding,
// opcodes, ALU operation codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  // Request from the FSM to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SR  = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode and branch-taken evaluation for the multicycle controller.
// Macro MC_CTRL_FULL_BRANCH_EN adds blt/bge/bltu/bgeu; otherwise only beq/bne.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  alu_op_e    alu_op_i,
  output logic [2:0] alu_ctrl_o,
  output logic       taken_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_ctrl_o = ALU_ADD;
    taken_o    = 1'b0;
    case (alu_op_i)
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (op_i == OP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl_o = ALU_AND;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b011:  alu_ctrl_o = ALU_XOR; // sltu shares this code; ALU picks by funct3
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b001:  alu_ctrl_o = ALU_SLL;
          default: alu_ctrl_o = ALU_SR;
        endcase
      end
      ALUOP_BRANCH: begin
        case (funct3_i)
          3'b000: begin alu_ctrl_o = ALU_SUB; taken_o =  zero_i; end
          3'b001: begin alu_ctrl_o = ALU_SUB; taken_o = !zero_i; end
`ifdef MC_CTRL_FULL_BRANCH_EN
          3'b100: begin alu_ctrl_o = ALU_SLT; taken_o = !zero_i; end
          3'b101: begin alu_ctrl_o = ALU_SLT; taken_o =  zero_i; end
          3'b110: begin alu_ctrl_o = ALU_XOR; taken_o = !zero_i; end
          3'b111: begin alu_ctrl_o = ALU_XOR; taken_o =  zero_i; end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback and drives
// datapath enables and mux selects. Optional macro: MC_CTRL_FULL_BRANCH_EN.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    taken;
  logic    pc_write_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;

  // NOTE: sequential state uses non-blocking assignment; reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  alu_decoder u_alu_decoder (
    .op_i       (op),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .zero_i     (zero),
    .alu_op_i   (alu_op),
    .alu_ctrl_o (alu_ctrl),
    .taken_o    (taken)
  );

  assign imm_src = imm_src_for(op);

  always_comb begin
    state_d     = state_q;
    alu_op      = ALUOP_ADD;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_BRANCH;
        pc_write_c = taken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset holds the FSM in FETCH; only the side-effecting strobes need masking.
  assign pc_write  = pc_write_c  & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign illegal   = illegal_c   & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instructions, a mid-instruction
// reset, then random instructions checked cycle by cycle against a reference model.
module tb_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctrl;
  outs_t      observed;

  int n_checks = 0;
  int n_pass   = 0;
  outs_t exp_q[$];

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_ctrl   (alu_ctrl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign observed = {pc_write, adr_src, mem_write, ir_write, reg_write,
                     result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ALU code for an arithmetic instruction, indexed by funct3.
  logic [2:0] arith_tbl [8] = '{3'b000, 3'b110, 3'b101, 3'b100, 3'b100, 3'b111, 3'b011, 3'b010};
  // Branch behaviour by funct3: ALU code, supported flag, and whether "taken" means zero set.
`ifdef MC_CTRL_FULL_BRANCH_EN
  logic [2:0] br_ctl_tbl [8] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b101, 3'b101, 3'b100, 3'b100};
  logic       br_ok_tbl  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
  logic [2:0] br_ctl_tbl [8] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  logic       br_ok_tbl  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
  logic       br_on_zero [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic legal(input logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BR || o == JL;
  endfunction

  function automatic outs_t mk(input logic pcw, adr, memw, irw, regw,
                               input logic [1:0] rs, a, b, imm,
                               input logic [2:0] alu, input logic ill);
    outs_t r;
    r = '{pcw, adr, memw, irw, regw, rs, a, b, imm, alu, ill};
    return r;
  endfunction

  // Expected per-cycle outputs of one whole instruction, from FETCH until its last cycle.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    logic [1:0] imm;
    logic [2:0] ctl;
    logic       tk;
    imm = imm_of(o);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, !legal(o)));
    if (o == LW || o == SW) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0));
      if (o == LW) begin
        exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 0));
      end else begin
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
      end
    end else if (o == RT || o == IT) begin
      ctl = arith_tbl[f3];
      if (o == RT && f3 == 3'b000 && f7) ctl = 3'b001;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00, imm, ctl, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
    end else if (o == BR) begin
      ctl = br_ctl_tbl[f3];
      tk  = br_ok_tbl[f3] && (br_on_zero[f3] ? z : !z);
      exp_q.push_back(mk(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, ctl, 0));
    end else if (o == JL) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
    end
  endtask

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Entered and left at a falling edge with the FSM in FETCH.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    build(o, f3, f7, z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("%s op=%b f3=%b f7=%b z=%b cyc%0d", tag, o, f3, f7, z, k),
            observed, exp_q[k]);
    end
    @(negedge clk);
  endtask

  outs_t fetch_in_reset;

  initial begin
    logic [6:0] ro;
    reset = 1'b1; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    fetch_in_reset = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    #2;
    check("reset_start", observed, fetch_in_reset);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_held", observed, fetch_in_reset);
    reset = 1'b0;

    run_instr("lw",      LW, 3'b010, 1'b0, 1'b0);
    run_instr("sw",      SW, 3'b010, 1'b0, 1'b1);
    run_instr("sub",     RT, 3'b000, 1'b1, 1'b0);
    run_instr("add",     RT, 3'b000, 1'b0, 1'b0);
    run_instr("sra",     RT, 3'b101, 1'b1, 1'b0);
    run_instr("addi_b30", IT, 3'b000, 1'b1, 1'b0);
    run_instr("sltiu",   IT, 3'b011, 1'b0, 1'b0);
    run_instr("beq_z1",  BR, 3'b000, 1'b0, 1'b1);
    run_instr("beq_z0",  BR, 3'b000, 1'b0, 1'b0);
    run_instr("bne_z0",  BR, 3'b001, 1'b0, 1'b0);
    run_instr("jal",     JL, 3'b000, 1'b0, 1'b0);
    run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0);
`ifdef MC_CTRL_FULL_BRANCH_EN
    run_instr("bltu_z0", BR, 3'b110, 1'b0, 1'b0);
    run_instr("bge_z0",  BR, 3'b101, 1'b0, 1'b0);
`endif

    // Reset while a load sits in MEMREAD: it must be abandoned without a write.
    build(LW, 3'b010, 1'b0, 1'b0);
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("lw_pre_reset cyc%0d", k), observed, exp_q[k]);
    end
    reset = 1'b1;
    #1;
    check("reset_in_memread", observed, fetch_in_reset);
    @(negedge clk);
    #1;
    check("reset_after_edge", observed, fetch_in_reset);
    @(negedge clk);
    reset = 1'b0;
    run_instr("lw_after_reset", LW, 3'b010, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0: ro = LW;
        1: ro = SW;
        2: ro = RT;
        3: ro = IT;
        4: ro = BR;
        5: ro = JL;
        default: begin
          ro = 7'($urandom_range(0, 127));
          if (legal(ro)) ro = 7'b1111111;
        end
      endcase
      run_instr($sformatf("rnd%0d", i), ro, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
